ac_level_scan_controller: RTL and testbench

- Sequences the AC-level VLC stage for one slice.
- Walks the slice's scan-ordered coefficient buffer across blocks in ProRes interleaved order: for each scan position 1..63, every block in turn.
- Splits the stream into zero-runs and nonzero levels, and drives the level encoder.
- Re-initialises the level encoder's previous-level context at slice start. Emits run/level pairs aligned to the encoder's fixed output latency for the bit packer.

---
 rtl/ac_level_scan_controller.sv | 247 ++++++++++++++++++++++++
 tb/tb_ac_level_scan_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_level_scan_controller.sv
// ac_level_scan_controller
//   Sequences the AC-level VLC stage of one slice. The slice's scan-ordered
//   coefficient buffer is walked in interleaved order (scan position 1..63
//   outer, block 0..num_blocks-1 inner). Zero coefficients extend the current
//   zero-run. Nonzero coefficients are handed to the level encoder, and their
//   preceding run is delayed to line up with the encoder's output.
//
// Optional feature macro: AC_SCAN_STATS_EN
//   When defined, adds output nz_count, the number of nonzero AC levels issued
//   in the current slice.
//
// Ports
//   clk          clock
//   reset        synchronous active-high reset
//   start        begins a slice when idle (a rising edge is required)
//   num_blocks   blocks in slice, sampled at start, clamped to 2^MAX_BLOCKS_LOG2
//   busy         high from accepted start until done
//   done         one-cycle pulse when the slice is fully flushed
//   buf_rd_en    coefficient buffer read strobe
//   buf_rd_addr  {block, scan_pos[5:0]}
//   buf_rd_data  read data, valid one cycle after buf_rd_en
//   enc_reset_n  active-low context reset to the level encoder
//   lvl_coeff    coefficient to the level encoder, 0 when not issuing
//   pair_valid   aligned with encoder output of a nonzero level
//   pair_run     zero-run preceding the qualified level
//   nz_count     (AC_SCAN_STATS_EN only) nonzero levels issued this slice
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for start
// ENC_RST  | enc_reset_n low for one cycle, run counter clear
// ENC_WAIT | encoder consumes its first-cycle init
// SCAN     | one buffer read per cycle
// FLUSH    | drain read + encoder pipeline (LEVEL_LAT+1 cycles)
// FIN      | done pulse
module ac_level_scan_controller #(
  parameter int MAX_BLOCKS_LOG2 = 3,
  parameter int COEFF_W         = 32,
  parameter int LEVEL_LAT       = 5,
  parameter int RUN_W           = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [MAX_BLOCKS_LOG2:0]   num_blocks,
  output logic                       busy,
  output logic                       done,
  output logic                       buf_rd_en,
  output logic [MAX_BLOCKS_LOG2+5:0] buf_rd_addr,
  input  logic [COEFF_W-1:0]         buf_rd_data,
  output logic                       enc_reset_n,
  output logic [COEFF_W-1:0]         lvl_coeff,
  output logic                       pair_valid,
  output logic [RUN_W-1:0]           pair_run
`ifdef AC_SCAN_STATS_EN
  ,output logic [MAX_BLOCKS_LOG2+5:0] nz_count
`endif
);

  localparam int NB_W    = MAX_BLOCKS_LOG2 + 1;
  localparam int BLK_W   = MAX_BLOCKS_LOG2;
  localparam int CNT_W   = MAX_BLOCKS_LOG2 + 6;
  localparam int FLUSH_W = $clog2(LEVEL_LAT + 2);
  localparam int MAX_NB  = 1 << MAX_BLOCKS_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_ENC_RST, S_ENC_WAIT, S_SCAN, S_FLUSH, S_FIN
  } state_t;

  state_t                            state_q, state_d;
  logic [NB_W-1:0]                   nb_q, nb_d;
  logic [BLK_W-1:0]                  blk_q, blk_d;
  logic [5:0]                        pos_q, pos_d;
  logic                              rd_en_q, rd_en_d;
  logic                              rd_pend_q, rd_pend_d;
  logic [FLUSH_W-1:0]                flush_q, flush_d;
  logic [RUN_W-1:0]                  run_q, run_d;
  logic [COEFF_W-1:0]                lvl_q, lvl_d;
  logic [LEVEL_LAT-1:0]              dl_vld_q, dl_vld_d;
  logic [LEVEL_LAT-1:0][RUN_W-1:0]   dl_run_q, dl_run_d;
  logic                              pair_vld_q, pair_vld_d;
  logic [RUN_W-1:0]                  pair_run_q, pair_run_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              enc_rst_n_q, enc_rst_n_d;
  logic                              start_prev_q;

  logic                              start_acc;
  logic [NB_W-1:0]                   nb_clamped;
  logic                              last_blk;
  logic                              push;

  // A held-high start must not launch back-to-back slices, so only a rising
  // edge seen in IDLE is accepted.
  assign start_acc  = start && !start_prev_q && (state_q == S_IDLE);
  assign nb_clamped = (num_blocks > NB_W'(MAX_NB)) ? NB_W'(MAX_NB) : num_blocks;
  assign last_blk   = ({1'b0, blk_q} == (nb_q - NB_W'(1)));

  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    blk_d   = blk_q;
    pos_d   = pos_q;
    rd_en_d = 1'b0;
    flush_d = flush_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          nb_d    = nb_clamped;
          state_d = (nb_clamped == '0) ? S_FIN : S_ENC_RST;
        end
      end
      S_ENC_RST:  state_d = S_ENC_WAIT;
      S_ENC_WAIT: begin
        state_d = S_SCAN;
        blk_d   = '0;
        pos_d   = 6'd1;
        rd_en_d = 1'b1;
      end
      S_SCAN: begin
        if (last_blk && (pos_q == 6'd63)) begin
          state_d = S_FLUSH;
          flush_d = FLUSH_W'(LEVEL_LAT);
        end else begin
          rd_en_d = 1'b1;
          if (last_blk) begin
            blk_d = '0;
            pos_d = pos_q + 6'd1;
          end else begin
            blk_d = blk_q + BLK_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (flush_q == '0) state_d = S_FIN;
        else               flush_d = flush_q - FLUSH_W'(1);
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs mirror the state being entered.
    busy_d      = (state_d == S_ENC_RST) || (state_d == S_ENC_WAIT) ||
                  (state_d == S_SCAN)    || (state_d == S_FLUSH);
    done_d      = (state_d == S_FIN);
    enc_rst_n_d = (state_d != S_ENC_RST);
  end

  always_comb begin
    rd_pend_d = rd_en_q;
    lvl_d     = '0;
    push      = 1'b0;
    run_d     = run_q;
    if (state_q == S_ENC_RST) begin
      run_d = '0;
    end else if (rd_pend_q) begin
      if (buf_rd_data == '0) begin
        run_d = (run_q == '1) ? run_q : run_q + RUN_W'(1);
      end else begin
        lvl_d = buf_rd_data;
        push  = 1'b1;
        run_d = '0;
      end
    end

    // Stage 0 loads alongside lvl_coeff; the output register adds the final
    // cycle so pair_* trails lvl_coeff by exactly LEVEL_LAT.
    dl_vld_d    = dl_vld_q;
    dl_run_d    = dl_run_q;
    dl_vld_d[0] = push;
    dl_run_d[0] = run_q;
    for (int i = 1; i < LEVEL_LAT; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_run_d[i] = dl_run_q[i-1];
    end
    pair_vld_d = dl_vld_q[LEVEL_LAT-1];
    pair_run_d = dl_run_q[LEVEL_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      nb_q         <= '0;
      blk_q        <= '0;
      pos_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      flush_q      <= '0;
      run_q        <= '0;
      lvl_q        <= '0;
      dl_vld_q     <= '0;
      dl_run_q     <= '0;
      pair_vld_q   <= 1'b0;
      pair_run_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      enc_rst_n_q  <= 1'b1;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nb_q         <= nb_d;
      blk_q        <= blk_d;
      pos_q        <= pos_d;
      rd_en_q      <= rd_en_d;
      rd_pend_q    <= rd_pend_d;
      flush_q      <= flush_d;
      run_q        <= run_d;
      lvl_q        <= lvl_d;
      dl_vld_q     <= dl_vld_d;
      dl_run_q     <= dl_run_d;
      pair_vld_q   <= pair_vld_d;
      pair_run_q   <= pair_run_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      enc_rst_n_q  <= enc_rst_n_d;
      start_prev_q <= start;
    end
  end

`ifdef AC_SCAN_STATS_EN
  logic [CNT_W-1:0] nz_q, nz_d;

  // Also cleared on an accepted start so an empty slice reports 0.
  always_comb begin
    nz_d = nz_q;
    if (start_acc || (state_q == S_ENC_RST)) nz_d = '0;
    else if (push)                           nz_d = nz_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) nz_q <= '0;
    else       nz_q <= nz_d;
  end

  assign nz_count = nz_q;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign buf_rd_en   = rd_en_q;
  assign buf_rd_addr = {blk_q, pos_q};
  assign enc_reset_n = enc_rst_n_q;
  assign lvl_coeff   = lvl_q;
  assign pair_valid  = pair_vld_q;
  assign pair_run    = pair_run_q;

endmodule

// File: tb/tb_ac_level_scan_controller.sv
module tb_ac_level_scan_controller;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  num_blocks;
  logic        busy, done, buf_rd_en, enc_reset_n, pair_valid;
  logic [8:0]  buf_rd_addr;
  logic [31:0] buf_rd_data;
  logic [31:0] lvl_coeff;
  logic [9:0]  pair_run;
`ifdef AC_SCAN_STATS_EN
  logic [8:0]  nz_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int mem [0:511];
  int seq_c[$];
  int seq_a[$];
  int seq_run[$];
  int model_nz;

  ac_level_scan_controller #(
    .MAX_BLOCKS_LOG2(3), .COEFF_W(32), .LEVEL_LAT(LAT), .RUN_W(10)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
    .busy(busy), .done(done), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data), .enc_reset_n(enc_reset_n), .lvl_coeff(lvl_coeff),
    .pair_valid(pair_valid), .pair_run(pair_run)
`ifdef AC_SCAN_STATS_EN
    , .nz_count(nz_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 0;
  endtask

  task automatic fill_random(input int density);
    for (int i = 0; i < 512; i++)
      mem[i] = ($urandom_range(0, 99) < density) ? ($urandom_range(1, 2000) - 1000 + 0) : 0;
    for (int i = 0; i < 512; i++) if (mem[i] == 0 && $urandom_range(0, 1) == 0) mem[i] = 0;
  endtask

  // Interleaved scan order and zero-run bookkeeping from first principles.
  task automatic build_model(input int n);
    int run;
    seq_c.delete(); seq_a.delete(); seq_run.delete();
    run = 0; model_nz = 0;
    for (int p = 1; p < 64; p++)
      for (int b = 0; b < n; b++) begin
        seq_a.push_back(b * 64 + p);
        seq_c.push_back(mem[b * 64 + p]);
        seq_run.push_back(run);
        if (mem[b * 64 + p] == 0) run++;
        else begin run = 0; model_nz++; end
      end
  endtask

  task automatic run_slice(input string name, input int nb_in, input bit hold);
    int n, total, k, len;
    logic exp_en, exp_pv, exp_busy, exp_done, exp_rstn;
    logic [31:0] exp_lvl;
    n = (nb_in > 8) ? 8 : nb_in;
    build_model(n);
    len = 63 * n;
    total = (n == 0) ? 1 : 4 + len + LAT;
    @(posedge clk); #1;
    start = 1'b1; num_blocks = 4'(nb_in);
    for (int t = 0; t <= total + 2; t++) begin
      @(negedge clk);
      exp_en   = (n > 0) && (t >= 3) && (t < 3 + len);
      exp_busy = (n > 0) && (t >= 1) && (t <= 3 + len + LAT);
      exp_done = (t == total);
      exp_rstn = !((n > 0) && (t == 1));
      k = t - 5;
      exp_lvl = (k >= 0 && k < len) ? 32'(seq_c[k]) : 32'd0;
      k = t - 5 - LAT;
      exp_pv = (k >= 0 && k < len) ? (seq_c[k] != 0) : 1'b0;
      n_checks++;
      if (buf_rd_en !== exp_en) begin n_fail++;
        $display("FAIL %s rd_en t=%0d got %b want %b", name, t, buf_rd_en, exp_en); end
      if (exp_en) begin
        n_checks++;
        if (buf_rd_addr !== 9'(seq_a[t-3])) begin n_fail++;
          $display("FAIL %s addr t=%0d got %0d want %0d", name, t, buf_rd_addr, seq_a[t-3]); end
      end
      n_checks++;
      if (lvl_coeff !== exp_lvl) begin n_fail++;
        $display("FAIL %s lvl t=%0d got %0d want %0d", name, t, $signed(lvl_coeff), $signed(exp_lvl)); end
      n_checks++;
      if (pair_valid !== exp_pv) begin n_fail++;
        $display("FAIL %s pair_valid t=%0d got %b want %b", name, t, pair_valid, exp_pv); end
      if (exp_pv) begin
        n_checks++;
        if (pair_run !== 10'(seq_run[k])) begin n_fail++;
          $display("FAIL %s pair_run t=%0d got %0d want %0d", name, t, pair_run, seq_run[k]); end
      end
      n_checks++;
      if (done !== exp_done) begin n_fail++;
        $display("FAIL %s done t=%0d got %b want %b", name, t, done, exp_done); end
      n_checks++;
      if (busy !== exp_busy) begin n_fail++;
        $display("FAIL %s busy t=%0d got %b want %b", name, t, busy, exp_busy); end
      n_checks++;
      if (enc_reset_n !== exp_rstn) begin n_fail++;
        $display("FAIL %s enc_reset_n t=%0d got %b want %b", name, t, enc_reset_n, exp_rstn); end
`ifdef AC_SCAN_STATS_EN
      if (t == total) begin
        n_checks++;
        if (nz_count !== 9'(model_nz)) begin n_fail++;
          $display("FAIL %s nz_count got %0d want %0d", name, nz_count, model_nz); end
      end
`endif
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
    end
    if (hold) begin
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || buf_rd_en !== 1'b0) begin n_fail++;
          $display("FAIL %s held_start extra activity busy=%b done=%b rd_en=%b want 0", name, busy, done, buf_rd_en); end
`ifdef AC_SCAN_STATS_EN
        n_checks++;
        if (nz_count !== 9'(model_nz)) begin n_fail++;
          $display("FAIL %s nz_count_hold got %0d want %0d", name, nz_count, model_nz); end
`endif
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_blocks = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || buf_rd_en !== 1'b0 || buf_rd_addr !== 9'd0 ||
        enc_reset_n !== 1'b1 || lvl_coeff !== 32'd0 || pair_valid !== 1'b0 || pair_run !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_values got busy=%b done=%b rd_en=%b addr=%0d rstn=%b lvl=%0d pv=%b pr=%0d want 0,0,0,0,1,0,0,0",
               busy, done, buf_rd_en, buf_rd_addr, enc_reset_n, lvl_coeff, pair_valid, pair_run);
    end
`ifdef AC_SCAN_STATS_EN
    n_checks++;
    if (nz_count !== 9'd0) begin n_fail++;
      $display("FAIL reset_nz_count got %0d want 0", nz_count); end
`endif
  endtask

  task automatic test_all_zero();
    clear_mem();
    run_slice("all_zero", 4, 1'b0);
  endtask

  task automatic test_two_levels();
    clear_mem();
    mem[0 * 64 + 1] = 5;
    mem[2 * 64 + 1] = -3;
    run_slice("two_levels", 4, 1'b0);
  endtask

  task automatic test_last_coeff();
    clear_mem();
    mem[7 * 64 + 63] = 1;
    run_slice("last_coeff", 8, 1'b0);
  endtask

  task automatic test_zero_blocks();
    fill_random(50);
    run_slice("zero_blocks", 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 512; i++) mem[i] = i + 1;
    @(posedge clk); #1;
    start = 1'b1; num_blocks = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pair_valid !== 1'b0 || lvl_coeff !== 32'd0 || buf_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got busy=%b pv=%b lvl=%0d rd_en=%b want all 0", busy, pair_valid, lvl_coeff, buf_rd_en);
    end
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || pair_valid !== 1'b0 || busy !== 1'b0) begin n_fail++;
        $display("FAIL mid_reset_quiet t=%0d got done=%b pv=%b busy=%b want 0", t, done, pair_valid, busy); end
    end
    fill_random(20);
    run_slice("after_reset", 4, 1'b0);
  endtask

  task automatic test_held_start();
    int placed;
    int a;
    clear_mem();
    placed = 0;
    while (placed < 17) begin
      a = $urandom_range(0, 2) * 64 + $urandom_range(1, 63);
      if (mem[a] == 0) begin
        mem[a] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 500)) : -int'($urandom_range(1, 500));
        placed++;
      end
    end
    run_slice("held_start", 3, 1'b1);
  endtask

  task automatic test_random();
    int nb;
    for (int it = 0; it < 6; it++) begin
      nb = (it == 5) ? int'($urandom_range(9, 15)) : int'($urandom_range(1, 8));
      fill_random(int'($urandom_range(5, 60)));
      run_slice($sformatf("random%0d", it), nb, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    fill_random(30);
    run_slice("b2b_a", 2, 1'b0);
    fill_random(30);
    run_slice("b2b_b", 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_two_levels();
    test_last_coeff();
    test_zero_blocks();
    test_mid_reset();
    test_held_start();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
